// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the sysid slave's ID
// (address 0) and build timestamp (address 1), compares both against the
// expected values and reports match flags, captured words and done status.
// Optional feature macro: SYSID_CHECK_TIMEOUT_EN adds a per-transaction
// wait-cycle limit (TIMEOUT_CYCLES) and the ERR state; without it the
// checker waits indefinitely and timeout is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start (or the one automatic run after reset)
// S_ID_REQ  | m_read to address 0, held until the slave accepts
// S_ID_WAIT | waiting for the ID word on m_readdatavalid
// S_TS_REQ  | m_read to address 1, held until the slave accepts
// S_TS_WAIT | waiting for the timestamp word on m_readdatavalid
// S_DONE    | one-cycle done pulse
// S_ERR     | transaction overran TIMEOUT_CYCLES (timeout build only)
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hCAFEDECA,
    parameter logic [31:0] EXPECTED_TS    = 32'h554260EF,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_DONE    = 3'd5
`ifdef SYSID_CHECK_TIMEOUT_EN
        ,
        S_ERR     = 3'd6
`endif
    } state_t;

    state_t state, state_nxt;
    logic   auto_pend;
    logic   check_begin;

    // A check begins on the IDLE -> ID_REQ transition; flags clear there.
    assign check_begin = (state == S_IDLE) && (state_nxt == S_ID_REQ);

`ifdef SYSID_CHECK_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt;
    logic        in_txn;
    logic        req_entry;

    assign in_txn    = state inside {S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT};
    assign req_entry = ((state_nxt == S_ID_REQ) && (state != S_ID_REQ)) ||
                       ((state_nxt == S_TS_REQ) && (state != S_TS_REQ));

    // Down-counter of remaining cycles for the current transaction; a value
    // of 1 means this is the last REQ/WAIT cycle allowed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            to_cnt <= 16'd0;
        else if (req_entry)
            to_cnt <= TO_LOAD;
        else if (in_txn && (to_cnt != 16'd0))
            to_cnt <= to_cnt - 16'd1;
    end

    // Sticky timeout flag: set on entry to ERR, cleared when a new check begins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            timeout <= 1'b0;
        else if (check_begin)
            timeout <= 1'b0;
        else if (state_nxt == S_ERR)
            timeout <= 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = |16'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and bus request decode.
    always_comb begin
        state_nxt = state;
        m_read    = 1'b0;
        m_address = 1'b0;
        case (state)
            S_IDLE:    if (start || auto_pend) state_nxt = S_ID_REQ;
            S_ID_REQ: begin
                m_read = 1'b1;
                if (!m_waitrequest) state_nxt = S_ID_WAIT;
            end
            S_ID_WAIT: if (m_readdatavalid) state_nxt = S_TS_REQ;
            S_TS_REQ: begin
                m_read    = 1'b1;
                m_address = 1'b1;
                if (!m_waitrequest) state_nxt = S_TS_WAIT;
            end
            S_TS_WAIT: if (m_readdatavalid) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
`ifdef SYSID_CHECK_TIMEOUT_EN
            S_ERR:     state_nxt = S_IDLE;
`endif
            default:   state_nxt = S_IDLE;
        endcase
`ifdef SYSID_CHECK_TIMEOUT_EN
        // Completion wins over an expiring budget in the same cycle.
        if (in_txn && (to_cnt == 16'd1) &&
            (state_nxt != S_TS_REQ) && (state_nxt != S_DONE)) begin
            state_nxt = S_ERR;
            m_read    = 1'b0;
        end
`endif
    end

    // Capture returned words, track match flags and the one-shot auto start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_START;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            id_value  <= 32'd0;
            ts_value  <= 32'd0;
        end else begin
            if (check_begin) begin
                auto_pend <= 1'b0;
                id_ok     <= 1'b0;
                ts_ok     <= 1'b0;
            end
            if ((state == S_ID_WAIT) && m_readdatavalid) begin
                id_value <= m_readdata;
                id_ok    <= (m_readdata == EXPECTED_ID);
            end
            if ((state == S_TS_WAIT) && m_readdatavalid) begin
                ts_value <= m_readdata;
                ts_ok    <= (m_readdata == EXPECTED_TS);
            end
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule
